// File: rtl/l2_bank_pipelined.sv
// l2_bank_pipelined
//   Single TCDM-slave L2 SRAM bank with generic width/depth/interleave,
//   configurable read latency, out-of-range error response and a hardware
//   zero-clear sequencer (automatic after reset and/or on clear_i).
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i, add_i,       TCDM request: byte address, wen_i (1 = read, 0 = write),
//   wen_i, be_i,        byte enables and write data
//   wdata_i
//   gnt_o               combinational grant
//   r_valid_o           response valid, READ_LATENCY cycles after each grant
//   r_rdata_o           read data (0 for write and out-of-range responses)
//   r_opc_o             response error (out-of-range, or parity when enabled)
//   clear_i             single-cycle pulse that starts the clear sequence
//   clear_busy_o        clear sequence in progress
//   clear_done_o        one-cycle pulse after the last word has been cleared
//   parity_err_o        sticky parity error (0 unless L2_BANK_PARITY_EN)
//
// Optional feature: define L2_BANK_PARITY_EN to store one even-parity bit per
// byte and flag mismatches on reads.
module l2_bank_pipelined #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BANK_WORDS    = 32768,
  parameter int unsigned NB_BANKS      = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h1C000000,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic [31:0]             add_i,
  input  logic                    wen_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    gnt_o,
  output logic                    r_valid_o,
  output logic [DATA_WIDTH-1:0]   r_rdata_o,
  output logic                    r_opc_o,
  input  logic                    clear_i,
  output logic                    clear_busy_o,
  output logic                    clear_done_o,
  output logic                    parity_err_o
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned BO     = $clog2(NBYTES);
  localparam int unsigned IB     = $clog2(NB_BANKS);
  localparam int unsigned AW     = $clog2(BANK_WORDS);
  localparam logic [63:0] SPAN   = 64'(BANK_WORDS) * 64'(NB_BANKS) * 64'(NBYTES);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

  logic [31:0]     off;
  logic [AW-1:0]   idx;
  logic            oor;
  logic            gnt;
  logic            s0_rd;
  logic            par_bad;
  logic [DATA_WIDTH-1:0] rdata_raw;

  logic [DATA_WIDTH-1:0] mem [BANK_WORDS];

  logic                  pv_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pd_q [READ_LATENCY];
  logic                  po_q [READ_LATENCY];

  // ---------------------------------------------------------------- decode
  // Address below BASE_ADDR wraps to a huge offset and is caught by the
  // range compare, done in 64 bits so the span itself cannot overflow.
  always_comb begin
    off = add_i - BASE_ADDR;
    idx = off[BO+IB +: AW];
    oor = ({32'd0, off} >= SPAN);
  end

  assign gnt       = req_i & (state_q == IDLE) & ~clear_i;
  assign gnt_o     = gnt;
  assign s0_rd     = gnt & wen_i & ~oor;
  assign rdata_raw = mem[idx];

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_i) state_d = CLEAR;
      end
      CLEAR: begin
        if (cnt_q == AW'(BANK_WORDS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= (INIT_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign clear_busy_o = (state_q == CLEAR);
  assign clear_done_o = done_q;

  // ---------------------------------------------------------------- array
`ifdef L2_BANK_PARITY_EN
  logic [NBYTES-1:0] par_mem [BANK_WORDS];
  logic [NBYTES-1:0] rd_par;
  logic              perr_q;

  always_comb begin
    for (int unsigned b = 0; b < NBYTES; b++) begin
      rd_par[b] = ^rdata_raw[8*b +: 8];
    end
    par_bad = |(rd_par ^ par_mem[idx]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perr_q <= 1'b0;
    end else if (s0_rd && par_bad) begin
      perr_q <= 1'b1;
    end
  end

  assign parity_err_o = perr_q;
`else
  assign par_bad      = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  // Clear and TCDM accesses never coincide: grant requires IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == CLEAR) begin
        mem[cnt_q] <= '0;
`ifdef L2_BANK_PARITY_EN
        par_mem[cnt_q] <= '0;
`endif
      end else if (gnt && !wen_i && !oor) begin
        for (int unsigned b = 0; b < NBYTES; b++) begin
          if (be_i[b]) begin
            mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
`ifdef L2_BANK_PARITY_EN
            par_mem[idx][b] <= ^wdata_i[8*b +: 8];
`endif
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- response
  // Stage 0 captures the response on the grant edge; further stages only
  // delay it, so one response leaves per grant at full throughput.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pv_q[i] <= 1'b0;
        pd_q[i] <= '0;
        po_q[i] <= 1'b0;
      end
    end else begin
      pv_q[0] <= gnt;
      pd_q[0] <= s0_rd ? rdata_raw : '0;
      po_q[0] <= gnt & (oor | (s0_rd & par_bad));
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
        po_q[i] <= po_q[i-1];
      end
    end
  end

  assign r_valid_o = pv_q[READ_LATENCY-1];
  assign r_rdata_o = pd_q[READ_LATENCY-1];
  assign r_opc_o   = po_q[READ_LATENCY-1];

endmodule

// File: tb/tb_l2_bank_pipelined.sv
// Testbench for l2_bank_pipelined: randomized traffic plus directed cases,
// checked cycle by cycle against a word-array / response-queue model.
// Build with L2_BANK_PARITY_EN defined to include the parity-corruption case.
module tb_l2_bank_pipelined;

  localparam int unsigned BW   = 16;
  localparam int unsigned NB   = 4;
  localparam int unsigned RL   = 3;
  localparam logic [31:0] BASE = 32'h1C000000;
  localparam int unsigned SPAN = BW * NB * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] add = '0;
  logic        wen = 1'b1;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_opc;
  logic        clr = 1'b0;
  logic        clear_busy;
  logic        clear_done;
  logic        parity_err;

  always #5 clk = ~clk;

  l2_bank_pipelined #(
    .DATA_WIDTH   (32),
    .BANK_WORDS   (BW),
    .NB_BANKS     (NB),
    .BASE_ADDR    (BASE),
    .READ_LATENCY (RL),
    .INIT_ON_RESET(1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .add_i       (add),
    .wen_i       (wen),
    .be_i        (be),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .r_valid_o   (r_valid),
    .r_rdata_o   (r_rdata),
    .r_opc_o     (r_opc),
    .clear_i     (clr),
    .clear_busy_o(clear_busy),
    .clear_done_o(clear_done),
    .parity_err_o(parity_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: word contents, corrupted-parity bytes, pending responses.
  typedef struct {
    int          due;
    logic [31:0] data;
    logic        opc;
  } rsp_t;

  logic [31:0] mref [BW];
  logic [3:0]  bad  [BW];
  rsp_t        rq [$];
  int          cyc        = 0;
  int          clear_left = BW;
  logic        done_pend  = 1'b0;
  logic        perr_ref   = 1'b0;

  // One clock cycle: check outputs, drive inputs, check grant, advance model.
  task automatic step(input logic r, input logic rq_v, input logic [31:0] a, input logic w,
                      input logic [3:0] b, input logic [31:0] d, input logic c,
                      output logic granted);
    logic        exp_gnt;
    logic [31:0] offs;
    logic        oor;
    logic [3:0]  ix;
    logic        done_nx;
    rsp_t        e;
    @(negedge clk);
    cyc++;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e = rq.pop_front();
      check_eq("r_valid", r_valid, 1);
      check_eq("r_rdata", r_rdata, e.data);
      check_eq("r_opc", r_opc, e.opc);
    end else begin
      check_eq("r_valid_idle", r_valid, 0);
      check_eq("r_rdata_idle", r_rdata, 0);
      check_eq("r_opc_idle", r_opc, 0);
    end
    check_eq("clear_busy", clear_busy, clear_left > 0);
    check_eq("clear_done", clear_done, done_pend);
    check_eq("parity_err", parity_err, perr_ref);

    rst = r; req = rq_v; add = a; wen = w; be = b; wdata = d; clr = c;
    #1;
    exp_gnt = !r && rq_v && (clear_left == 0) && !c;
    if (!r) check_eq("gnt", gnt, exp_gnt);
    granted = exp_gnt;

    if (r) begin
      rq.delete();
      clear_left = BW;
      done_pend  = 1'b0;
      perr_ref   = 1'b0;
      return;
    end

    if (exp_gnt) begin
      offs = a - BASE;
      oor  = (offs >= SPAN);
      ix   = offs[7:4];
      if (w) begin
        e.due  = cyc + RL;
        e.data = oor ? 32'd0 : mref[ix];
        e.opc  = oor || (bad[ix] != 0);
        if (!oor && bad[ix] != 0) perr_ref = 1'b1;
      end else begin
        e.due  = cyc + RL;
        e.data = 32'd0;
        e.opc  = oor;
        if (!oor) begin
          for (int k = 0; k < 4; k++) begin
            if (b[k]) begin
              mref[ix][8*k +: 8] = d[8*k +: 8];
              bad[ix][k] = 1'b0;
            end
          end
        end
      end
      rq.push_back(e);
    end

    done_nx = 1'b0;
    if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) begin
        done_nx = 1'b1;
        for (int k = 0; k < int'(BW); k++) begin
          mref[k] = '0;
          bad[k]  = '0;
        end
      end
    end else if (c) begin
      clear_left = BW;
    end
    done_pend = done_nx;
  endtask

  task automatic idle(input int n);
    logic g;
    for (int k = 0; k < n; k++) step(0, 0, BASE, 1, 4'h0, 32'd0, 0, g);
  endtask

  // Holds a request until granted; returns the number of cycles spent waiting.
  task automatic access(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, input logic c, output int waits);
    logic g;
    waits = 0;
    step(0, 1, a, w, b, d, c, g);
    while (!g && waits < 64) begin
      waits++;
      step(0, 1, a, w, b, d, 0, g);
    end
    if (!g) check_eq("grant_timeout", 0, 1);
  endtask

  initial begin
    logic        g;
    logic        pend;
    logic        pr, pw;
    logic [31:0] pa, pd;
    logic [3:0]  pb;
    logic        rs, cl;
    int          waits;

    for (int k = 0; k < int'(BW); k++) begin
      mref[k] = '0;
      bad[k]  = '0;
    end

    // Reset, then a read of idx 5 requested throughout the init clear.
    step(1, 0, BASE, 1, 4'h0, 32'd0, 0, g);
    step(1, 0, BASE, 1, 4'h0, 32'd0, 0, g);
    access(BASE + 32'h50, 1, 4'h0, 32'd0, 0, waits);
    check_eq("init_wait", waits, BW);

    // Partial-byte write then read back.
    access(BASE + 32'h10, 0, 4'b0011, 32'hDEADBEEF, 0, waits);
    access(BASE + 32'h10, 1, 4'h0, 32'd0, 0, waits);
    check_eq("rd_wait", waits, 0);

    // Back-to-back reads, then out-of-range at both ends.
    access(BASE + 32'h00, 0, 4'hF, 32'h11111111, 0, waits);
    access(BASE + 32'h40, 0, 4'hF, 32'h22222222, 0, waits);
    access(BASE + 32'h00, 1, 4'h0, 32'd0, 0, waits);
    access(BASE + 32'h40, 1, 4'h0, 32'd0, 0, waits);
    access(BASE + 32'h10, 1, 4'h0, 32'd0, 0, waits);
    access(BASE + 32'hF0, 1, 4'h0, 32'd0, 0, waits);
    access(BASE - 32'd4, 1, 4'h0, 32'd0, 0, waits);
    access(BASE + SPAN, 1, 4'h0, 32'd0, 0, waits);
    access(BASE + SPAN, 0, 4'hF, 32'hFFFFFFFF, 0, waits);
    idle(RL + 1);

    // Clear and request in the same cycle: clear wins.
    access(BASE + 32'h10, 1, 4'h0, 32'd0, 1, waits);
    check_eq("clear_req_wait", waits, BW + 1);
    idle(RL + 1);

    // Randomized traffic with occasional clears and resets.
    pend = 1'b0;
    pr = 0; pw = 0; pa = BASE; pd = 0; pb = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!pend) begin
        pr = ($urandom_range(0, 3) != 0);
        pa = BASE + $urandom_range(0, SPAN + 31) - 32'd16;
        pw = 1'($urandom_range(0, 1));
        pb = 4'($urandom_range(0, 15));
        pd = $urandom;
      end
      cl = ($urandom_range(0, 59) == 0);
      rs = ($urandom_range(0, 299) == 0);
      step(rs, pr, pa, pw, pb, pd, cl, g);
      pend = pr && !g && !rs;
    end
    idle(BW + RL + 2);

`ifdef L2_BANK_PARITY_EN
    access(BASE + 32'h20, 0, 4'hF, 32'h01020304, 0, waits);
    idle(RL + 1);
    dut.par_mem[2][0] = ~dut.par_mem[2][0];
    bad[2][0] = 1'b1;
    access(BASE + 32'h20, 1, 4'h0, 32'd0, 0, waits);
    access(BASE + 32'h30, 1, 4'h0, 32'd0, 0, waits);
    idle(RL + 4);
    step(1, 0, BASE, 1, 4'h0, 32'd0, 0, g);
    idle(BW + 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l2_bank_pipelined.md
Name: l2_bank_pipelined

Overview:
- Parametrised successor of the fixed one-cycle L2 SRAM bank wrapper: a single TCDM-slave bank with generic data width, depth, interleave factor and base address.
- Adds configurable read latency, out-of-range error response, and a hardware zero-clear sequencer run after reset or on request.
- One instance per interleaved or private bank in the SoC L2 array.

Parameters:
- DATA_WIDTH, 32: word width in bits; multiple of 8, power of two.
- BANK_WORDS, 32768: bank depth in words; power of two.
- NB_BANKS, 4: interleave factor; 1 means a private (non-interleaved) bank.
- BASE_ADDR, 32'h1C000000: byte address of word 0 of the bank group.
- READ_LATENCY, 1: cycles from grant to r_valid_o; range 1..4.
- INIT_ON_RESET, 1: if 1, clear sequence starts automatically on reset release.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  1  TCDM request.
- add_i  in  32  byte address.
- wen_i  in  1  1 = read, 0 = write.
- be_i  in  DATA_WIDTH/8  byte enables.
- wdata_i  in  DATA_WIDTH  write data.
- gnt_o  out  1  grant.
- r_valid_o  out  1  response valid.
- r_rdata_o  out  DATA_WIDTH  read data.
- r_opc_o  out  1  response error.
- clear_i  in  1  start clear sequence (single-cycle pulse).
- clear_busy_o  out  1  clear sequence in progress.
- clear_done_o  out  1  one-cycle pulse on completion.
- parity_err_o  out  1  sticky parity error (see Optional Feature).

Behaviour:
- Reset: clk_i and rst_i only; reset is synchronous and active-high.
- Reset values: r_valid_o=0, r_opc_o=0, r_rdata_o=0, clear_done_o=0, parity_err_o=0.
  - clear_busy_o = INIT_ON_RESET in the first cycle after reset release.
  - Memory contents are not reset.
- Address decode:
  - off = add_i - BASE_ADDR (32-bit, wraps).
  - BO = log2(DATA_WIDTH/8).
  - idx = off[log2(BANK_WORDS)+BO+log2(NB_BANKS)-1 : BO+log2(NB_BANKS)].
  - Out-of-range when off >= BANK_WORDS*NB_BANKS*(DATA_WIDTH/8); includes add_i < BASE_ADDR via wrap.
- FSM states IDLE, CLEAR:
  - Reset → CLEAR if INIT_ON_RESET else IDLE.
  - IDLE → CLEAR when clear_i=1.
  - CLEAR writes all-zero data (all bytes) to word cnt each cycle, cnt 0..BANK_WORDS-1.
  - At cnt = BANK_WORDS-1: → IDLE and clear_done_o=1 for the following cycle; cnt resets to 0.
  - clear_i in CLEAR is ignored (no restart).
  - clear_busy_o = (state==CLEAR).
- Grant: gnt_o = req_i & (state==IDLE) & ~clear_i. Combinational, no wait states otherwise.
  - clear_i has priority over a simultaneous request.
  - Requester holds req_i and its fields until granted.
- Granted write: bytes with be_i=1 updated on the grant edge. be_i=0 write is a no-op but still gets a response.
- Granted read: data sampled from the array on the grant edge.
- Response:
  - r_valid_o=1 exactly READ_LATENCY cycles after each grant, reads and writes alike, one response per grant.
  - Back-to-back grants give back-to-back responses; the pipeline is fully throughput-1.
  - r_rdata_o is valid for reads only and 0 for write responses.
  - Read-after-write to the same word in consecutive cycles returns the new data.
- Out-of-range: granted, no array access; response carries r_opc_o=1, r_rdata_o=0.
- In-flight responses keep draining while the FSM enters CLEAR.
- rst_i mid-operation: pipeline valids flushed (no responses for prior grants), cnt=0, FSM restarts per INIT_ON_RESET.

Optional Feature:
- Macro: L2_BANK_PARITY_EN.
- Defined:
  - One even-parity bit stored per byte, written with each enabled byte; clear writes parity 0.
  - On read, any mismatch in the addressed word sets r_opc_o=1 on that response (data still returned) and sets parity_err_o, sticky until rst_i.
- Undefined:
  - No parity storage; parity_err_o tied 0.
  - r_opc_o only reports out-of-range.

Test Plan:
- INIT_ON_RESET=1, BANK_WORDS=16: release reset → clear_busy_o high 16 cycles, gnt_o=0 throughout, clear_done_o pulse; read idx 5 → 0.
- READ_LATENCY=3: write 0xDEADBEEF to BASE_ADDR+0x10 with be=4'b0011, then read → r_valid_o 3 cycles after each grant, data 0x0000BEEF.
- Back-to-back reads of 4 addresses each cycle → 4 consecutive r_valid_o, data in order, no gaps.
- Read at BASE_ADDR-4 and BASE_ADDR+BANK_WORDS*NB_BANKS*4 → r_opc_o=1, r_rdata_o=0.
- clear_i and req_i in the same cycle → gnt_o=0; request granted only after clear_done_o.
- L2_BANK_PARITY_EN: write 0x01020304, force-flip the stored parity of byte 0, read → r_opc_o=1 and parity_err_o stays 1 until rst_i.
